dsp_acc4_seq: RTL and testbench
===============================

DSP_ACC4_SEQ -- requirements
Module: dsp_acc4_seq

Interface
REQ-001 SHALL have parameter TAPS, default 4, meaning beats (4-operand sums) per accumulation group; legal range 2..64.
REQ-002 SHALL have parameter LAT, default 3, meaning cycles from an operand beat at the accumulator inputs to its effect at the accumulator result; legal range 1..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clken, input, 1, global enable; when low, all internal state holds.
REQ-006 SHALL have port flush, input, 1, synchronous abort of the current group and pipeline contents.
REQ-007 SHALL have port in_valid, input, 1, upstream operand beat valid.
REQ-008 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready && clken.
REQ-009 SHALL have port acc_clken, output, 1, drives the accumulator clken.
REQ-010 SHALL have port acc_dsp_reset, output, 1, drives the accumulator dsp_reset.
REQ-011 SHALL have port acc_mode, output, 1, accumulator mode: 0 = pre-load, 1 = accumulate.
REQ-012 SHALL have port acc_op_en, output, 1, datapath forces all operands and carry-ins to zero when low.
REQ-013 SHALL have port res_valid, output, 1, accumulator result holds a completed group sum.
REQ-014 SHALL have port res_ready, input, 1, downstream accepts the result when res_valid && res_ready && clken.

Function
REQ-015 SHALL implement states INIT, RUN and FLUSH.
REQ-016 SHALL, in INIT, assert acc_dsp_reset and hold in_ready low for exactly LAT enabled cycles, then enter RUN.
REQ-017 SHALL define stall = res_valid && !res_ready, and drive acc_clken = clken && !stall.
REQ-018 SHALL, in RUN, drive in_ready = !stall.
REQ-019 SHALL drive acc_op_en high only in the cycle a beat is accepted; bubbles enter the pipeline as zero operands.
REQ-020 SHALL keep a beat counter 0..TAPS-1, incremented per accepted beat and wrapping from TAPS-1 to 0.
REQ-021 SHALL drive acc_mode = 0 when the counter is 0, else 1.
REQ-022 SHALL hold acc_mode = 1 during bubbles inside a group, so zero operands leave the accumulated sum unchanged.
REQ-023 SHALL shift a LAT-deep marker pipeline on every acc_clken cycle; the marker is set when the beat at counter TAPS-1 is accepted.
REQ-024 SHALL assert res_valid when a marker exits the pipeline, and hold it until it is accepted.
REQ-025 SHALL freeze the marker pipeline, the counter and the accumulator (via acc_clken) during stall, so the result stays stable.
REQ-026 SHALL give a first-group result LAT cycles after the last accepted beat when there are no stalls; back-to-back groups SHALL sustain one beat per cycle.
REQ-027 SHALL, on flush in any state, clear the counter, markers and res_valid, enter FLUSH, and discard any pending result.
REQ-028 SHALL, in FLUSH, behave as INIT: acc_dsp_reset high and in_ready low for LAT cycles, then return to RUN.
REQ-029 SHALL restart the LAT count if flush is asserted again during FLUSH.
REQ-030 SHALL give flush priority over a simultaneous beat accept; that beat is dropped.
REQ-031 SHALL NOT change acc_dsp_reset while clken is low.

Reset
REQ-032 SHALL, while aresetn is low, force state INIT and clear the INIT count, counter and markers.
REQ-033 SHALL, while aresetn is low, drive: in_ready 0, res_valid 0, acc_op_en 0, acc_mode 0, acc_dsp_reset 1, acc_clken = clken.
REQ-034 SHALL, if reset is asserted mid-group, discard partial sums; the first group after reset starts at counter 0.

Verification
REQ-035 Reset release, TAPS=4, LAT=3, in_valid held high -> in_ready rises on cycle 3; acc_mode pattern 0,1,1,1,0,…; res_valid first high 3 cycles after the 4th beat.
REQ-036 Streaming 3 groups with res_ready=1 -> res_valid pulses every 4 cycles; accumulator sum per group equals the sum of the 16 products (scoreboard against a reference model).
REQ-037 res_ready low for 5 cycles while res_valid is high -> acc_clken and in_ready low for those 5 cycles; the result stays unchanged; no beat is lost.
REQ-038 in_valid gaps (beats at cycles 0, 2, 5, 6) -> acc_op_en is high only on those cycles; the group result equals the sum of the 4 beats.
REQ-039 flush after beat 2 of a group with a pending res_valid -> res_valid drops next cycle; acc_dsp_reset is high for 3 cycles; the next beat gets acc_mode=0.
REQ-040 aresetn pulse mid-group plus clken toggling -> outputs take reset values immediately; state holds while clken is low; normal sequencing resumes.

Source files
------------

// File: rtl/dsp_acc4_seq.sv
// Sequencer for a 4-operand DSP accumulator: groups TAPS beats per sum, tracks
// result latency with a marker pipeline, and manages reset/flush of the datapath.
module dsp_acc4_seq #(
    parameter int TAPS = 4,
    parameter int LAT  = 3
) (
    input  logic clk,
    input  logic aresetn,
    input  logic clken,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    output logic acc_clken,
    output logic acc_dsp_reset,
    output logic acc_mode,
    output logic acc_op_en,
    output logic res_valid,
    input  logic res_ready
);

    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int IW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]     state;
    logic [IW-1:0]  wait_cnt;
    logic [CW-1:0]  beat_cnt;
    logic [LAT-1:0] marker;
    logic [LAT-1:0] marker_next;
    logic           stall;
    logic           take;
    logic           last_beat;

    // The last marker stage doubles as res_valid, so freezing the pipeline holds the result.
    assign res_valid     = marker[LAT-1];
    assign stall         = res_valid && !res_ready;
    assign acc_clken     = clken && !stall;
    assign in_ready      = (state == ST_RUN) && !stall;
    assign take          = in_valid && in_ready && clken && !flush;
    assign acc_op_en     = take;
    assign acc_mode      = (beat_cnt != '0);
    assign acc_dsp_reset = (state != ST_RUN);
    assign last_beat     = (beat_cnt == CW'(TAPS - 1));

    always_comb begin
        marker_next    = marker << 1;
        marker_next[0] = take && last_beat;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_INIT;
            wait_cnt <= '0;
            beat_cnt <= '0;
            marker   <= '0;
        end else if (clken) begin
            if (flush) begin
                state    <= ST_FLUSH;
                wait_cnt <= '0;
                beat_cnt <= '0;
                marker   <= '0;
            end else begin
                case (state)
                    ST_INIT, ST_FLUSH: begin
                        if (wait_cnt == IW'(LAT - 1)) begin
                            state    <= ST_RUN;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + IW'(1);
                        end
                    end
                    ST_RUN: state <= ST_RUN;
                    default: begin
                        state    <= ST_INIT;
                        wait_cnt <= '0;
                    end
                endcase
                if (take) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
                end
                if (!stall) begin
                    marker <= marker_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_acc4_seq.sv
// Bench for dsp_acc4_seq: drives randomized beats, models the external accumulator
// and checks each delivered group sum against a per-group scoreboard.
module tb_dsp_acc4_seq;

    localparam int TAPS = 4;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic aresetn, clken, flush, in_valid, res_ready;
    logic in_ready, acc_clken, acc_dsp_reset, acc_mode, acc_op_en, res_valid;

    int total = 0;
    int bad   = 0;
    int results = 0;
    int unsigned cur_beat = 0;

    int unsigned exp_q[$];
    int unsigned part = 0;
    int          part_n = 0;

    int unsigned pv[LAT-1];
    logic        pm[LAT-1];
    int unsigned acc_m = 0;

    logic c_rst_n, c_clken, c_flush, c_acc_clken, c_dsp_rst, c_mode, c_op_en;
    logic c_in_valid, c_in_ready, c_res_valid, c_res_ready;
    int unsigned c_beat;

    always #5 clk = ~clk;

    dsp_acc4_seq #(.TAPS(TAPS), .LAT(LAT)) dut (
        .clk(clk), .aresetn(aresetn), .clken(clken), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .acc_clken(acc_clken),
        .acc_dsp_reset(acc_dsp_reset), .acc_mode(acc_mode), .acc_op_en(acc_op_en),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    function automatic int unsigned rand_beat();
        int unsigned s = 0;
        for (int k = 0; k < 4; k++) s += $urandom_range(0, 255) * $urandom_range(0, 255);
        return s;
    endfunction

    always @(negedge clk) begin
        c_rst_n = aresetn; c_clken = clken; c_flush = flush; c_acc_clken = acc_clken;
        c_dsp_rst = acc_dsp_reset; c_mode = acc_mode; c_op_en = acc_op_en;
        c_in_valid = in_valid; c_in_ready = in_ready; c_res_valid = res_valid;
        c_res_ready = res_ready; c_beat = cur_beat;
    end

    // Group scoreboard plus a behavioural accumulator driven by the sequencer outputs.
    always @(posedge clk) begin
        int unsigned e;
        if (c_rst_n === 1'b1 && c_res_valid && c_res_ready && c_clken) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL res_unexpected: result handshake with no completed group, acc=%0d", acc_m);
            end else begin
                e = exp_q.pop_front();
                results++;
                if (acc_m !== e) begin
                    bad++;
                    $display("FAIL res_sum: got %0d expected %0d", acc_m, e);
                end
            end
        end
        if (c_rst_n !== 1'b1 || (c_clken && c_flush)) begin
            exp_q.delete();
            part = 0;
            part_n = 0;
        end else if (c_in_valid && c_in_ready && c_clken) begin
            part += c_beat;
            part_n++;
            if (part_n == TAPS) begin
                exp_q.push_back(part);
                part = 0;
                part_n = 0;
            end
        end
        if (c_acc_clken === 1'b1) begin
            if (c_dsp_rst) begin
                acc_m = 0;
                for (int i = 0; i < LAT-1; i++) begin pv[i] = 0; pm[i] = 1'b0; end
            end else begin
                acc_m = pm[LAT-2] ? acc_m + pv[LAT-2] : pv[LAT-2];
                for (int i = LAT-2; i > 0; i--) begin pv[i] = pv[i-1]; pm[i] = pm[i-1]; end
                pv[0] = c_op_en ? c_beat : 0;
                pm[0] = c_mode;
            end
        end
    end

    task automatic test_reset();
        aresetn = 1'b0; clken = 1'b1; flush = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < LAT-1; i++) begin pv[i] = 0; pm[i] = 1'b0; end
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        total++; if (acc_op_en !== 1'b0) begin bad++; $display("FAIL rst_op_en: got %b want 0", acc_op_en); end
        total++; if (acc_mode !== 1'b0) begin bad++; $display("FAIL rst_mode: got %b want 0", acc_mode); end
        total++; if (acc_dsp_reset !== 1'b1) begin bad++; $display("FAIL rst_dsp_reset: got %b want 1", acc_dsp_reset); end
        total++; if (acc_clken !== 1'b1) begin bad++; $display("FAIL rst_acc_clken_hi: got %b want 1", acc_clken); end
        clken = 1'b0;
        #1;
        total++; if (acc_clken !== 1'b0) begin bad++; $display("FAIL rst_acc_clken_lo: got %b want 0", acc_clken); end
        clken = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_init_stream();
        int r0 = results;
        logic ir_e, md_e, rv_e;
        aresetn = 1'b1;
        for (int cyc = 0; cyc < 21; cyc++) begin
            in_valid = (cyc < 15);
            cur_beat = rand_beat();
            @(negedge clk);
            ir_e = (cyc >= LAT);
            md_e = (cyc >= LAT) && ((cyc - LAT) % TAPS != 0);
            rv_e = (cyc >= 9) && (cyc <= 17) && ((cyc - 9) % TAPS == 0);
            total++; if (in_ready !== ir_e) begin bad++; $display("FAIL init_in_ready c%0d: got %b want %b", cyc, in_ready, ir_e); end
            if (cyc < 15) begin
                total++; if (acc_mode !== md_e) begin bad++; $display("FAIL init_mode c%0d: got %b want %b", cyc, acc_mode, md_e); end
            end
            total++; if (res_valid !== rv_e) begin bad++; $display("FAIL init_res_valid c%0d: got %b want %b", cyc, res_valid, rv_e); end
            @(posedge clk); #1;
        end
        total++; if (results - r0 !== 3) begin bad++; $display("FAIL init_groups: got %0d want 3", results - r0); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL init_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int r0 = results;
        logic st, rv_e;
        for (int cyc = 0; cyc < 19; cyc++) begin
            in_valid = (cyc <= 12);
            st = (cyc >= 6 && cyc <= 10);
            res_ready = !st;
            cur_beat = rand_beat();
            @(negedge clk);
            rv_e = (cyc >= 6 && cyc <= 11) || cyc == 15;
            total++; if (res_valid !== rv_e) begin bad++; $display("FAIL stall_res_valid c%0d: got %b want %b", cyc, res_valid, rv_e); end
            total++; if (acc_clken !== !st) begin bad++; $display("FAIL stall_acc_clken c%0d: got %b want %b", cyc, acc_clken, !st); end
            total++; if (in_ready !== !st) begin bad++; $display("FAIL stall_in_ready c%0d: got %b want %b", cyc, in_ready, !st); end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        total++; if (results - r0 !== 2) begin bad++; $display("FAIL stall_groups: got %0d want 2", results - r0); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stall_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_gaps();
        int r0 = results;
        logic md_e;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (cyc == 0 || cyc == 2 || cyc == 5 || cyc == 6);
            cur_beat = rand_beat();
            @(negedge clk);
            md_e = (cyc >= 1 && cyc <= 6);
            total++; if (acc_op_en !== in_valid) begin bad++; $display("FAIL gap_op_en c%0d: got %b want %b", cyc, acc_op_en, in_valid); end
            total++; if (acc_mode !== md_e) begin bad++; $display("FAIL gap_mode c%0d: got %b want %b", cyc, acc_mode, md_e); end
            total++; if (res_valid !== (cyc == 9)) begin bad++; $display("FAIL gap_res_valid c%0d: got %b want %b", cyc, res_valid, cyc == 9); end
            @(posedge clk); #1;
        end
        total++; if (results - r0 !== 1) begin bad++; $display("FAIL gap_groups: got %0d want 1", results - r0); end
    endtask

    task automatic test_flush();
        int r0 = results;
        logic rs_e, ir_e, op_e, rv_e;
        for (int cyc = 0; cyc < 28; cyc++) begin
            in_valid  = (cyc <= 21);
            res_ready = !(cyc == 6 || cyc == 7);
            flush     = (cyc == 7 || cyc == 12 || cyc == 14);
            cur_beat  = rand_beat();
            @(negedge clk);
            rs_e = (cyc >= 8 && cyc <= 10) || (cyc >= 13 && cyc <= 17);
            ir_e = !((cyc >= 6 && cyc <= 10) || (cyc >= 13 && cyc <= 17));
            op_e = ir_e && (cyc <= 21) && !flush;
            rv_e = (cyc == 6 || cyc == 7 || cyc == 24);
            total++; if (acc_dsp_reset !== rs_e) begin bad++; $display("FAIL flush_dsp_reset c%0d: got %b want %b", cyc, acc_dsp_reset, rs_e); end
            total++; if (in_ready !== ir_e) begin bad++; $display("FAIL flush_in_ready c%0d: got %b want %b", cyc, in_ready, ir_e); end
            total++; if (acc_op_en !== op_e) begin bad++; $display("FAIL flush_op_en c%0d: got %b want %b", cyc, acc_op_en, op_e); end
            total++; if (res_valid !== rv_e) begin bad++; $display("FAIL flush_res_valid c%0d: got %b want %b", cyc, res_valid, rv_e); end
            if (cyc == 11 || cyc == 18) begin
                total++; if (acc_mode !== 1'b0) begin bad++; $display("FAIL flush_first_mode c%0d: got %b want 0", cyc, acc_mode); end
            end
            @(posedge clk); #1;
        end
        flush = 1'b0; res_ready = 1'b1;
        total++; if (results - r0 !== 1) begin bad++; $display("FAIL flush_groups: got %0d want 1", results - r0); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL flush_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int r0 = results;
        int en_count = 0;
        int bcnt = 0;
        in_valid = 1'b1; clken = 1'b1; res_ready = 1'b1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            cur_beat = rand_beat();
            @(posedge clk); #1;
        end
        #2;
        aresetn = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        total++; if (acc_mode !== 1'b0) begin bad++; $display("FAIL mid_mode: got %b want 0", acc_mode); end
        total++; if (acc_op_en !== 1'b0) begin bad++; $display("FAIL mid_op_en: got %b want 0", acc_op_en); end
        total++; if (acc_dsp_reset !== 1'b1) begin bad++; $display("FAIL mid_dsp_reset: got %b want 1", acc_dsp_reset); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_res_valid: got %b want 0", res_valid); end
        @(posedge clk); #1;
        aresetn = 1'b1;
        for (int cyc = 0; cyc < 42; cyc++) begin
            clken    = (cyc >= 32) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_valid = (cyc < 32);
            cur_beat = rand_beat();
            @(negedge clk);
            total++; if (in_ready !== (en_count >= LAT)) begin bad++; $display("FAIL ck_in_ready c%0d: got %b want %b", cyc, in_ready, en_count >= LAT); end
            total++; if (acc_dsp_reset !== (en_count < LAT)) begin bad++; $display("FAIL ck_dsp_reset c%0d: got %b want %b", cyc, acc_dsp_reset, en_count < LAT); end
            total++; if (acc_clken !== clken) begin bad++; $display("FAIL ck_acc_clken c%0d: got %b want %b", cyc, acc_clken, clken); end
            if (en_count >= LAT && cyc < 32) begin
                total++; if (acc_mode !== (bcnt % TAPS != 0)) begin bad++; $display("FAIL ck_mode c%0d: got %b want %b", cyc, acc_mode, bcnt % TAPS != 0); end
            end
            if (clken) begin
                if (en_count >= LAT && in_valid) bcnt++;
                en_count++;
            end
            @(posedge clk); #1;
        end
        total++; if (results - r0 !== bcnt / TAPS) begin bad++; $display("FAIL ck_groups: got %0d want %0d", results - r0, bcnt / TAPS); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ck_pending: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_init_stream();
        test_stall();
        test_gaps();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
